// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-port bundle for ram_port_arbiter; the arbiter takes the slave side.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_ack;
  logic [DATA_W-1:0] r0_rdata;
  logic              r0_rvalid;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_ack;
  logic [DATA_W-1:0] r1_rdata;
  logic              r1_rvalid;

  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_ack, r0_rdata, r0_rvalid,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_ack, r1_rdata, r1_rvalid,
    output ena, wea, addra, dina,
    input  douta
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_ack, r0_rdata, r0_rvalid,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_ack, r1_rdata, r1_rvalid,
    input  ena, wea, addra, dina,
    output douta
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port block RAM,
// with a tagged read-return pipeline matched to the RAM read latency.
module ram_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clka,
  input  logic                rst,
  ram_port_arbiter_if.slave   bus
);

  logic              elig0, elig1;
  logic              grant0, grant1;
  logic              ptr;
  logic [RD_LAT-1:0] pv, pid;
  logic [RD_LAT:0]   pv_nxt, pid_nxt;

  // The top bit of each *_nxt vector is the pipeline head; the rest is the shifted state.
  always_comb begin
    elig0   = bus.r0_req & ~bus.r0_ack;
    elig1   = bus.r1_req & ~bus.r1_ack;
    grant0  = elig0 & (~elig1 | ~ptr);
    grant1  = elig1 & (~elig0 |  ptr);
    pv_nxt  = {pv,  bus.ena & ~bus.wea};
    pid_nxt = {pid, bus.r1_ack};
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      bus.ena       <= 1'b0;
      bus.wea       <= 1'b0;
      bus.addra     <= '0;
      bus.dina      <= '0;
      bus.r0_ack    <= 1'b0;
      bus.r1_ack    <= 1'b0;
      bus.r0_rvalid <= 1'b0;
      bus.r1_rvalid <= 1'b0;
      bus.r0_rdata  <= '0;
      bus.r1_rdata  <= '0;
      ptr           <= 1'b0;
      pv            <= '0;
      pid           <= '0;
    end else begin
      bus.ena    <= grant0 | grant1;
      bus.wea    <= (grant0 & bus.r0_we) | (grant1 & bus.r1_we);
      bus.r0_ack <= grant0;
      bus.r1_ack <= grant1;
      if (grant0) begin
        bus.addra <= bus.r0_addr;
        bus.dina  <= bus.r0_wdata;
        ptr       <= 1'b1;
      end else if (grant1) begin
        bus.addra <= bus.r1_addr;
        bus.dina  <= bus.r1_wdata;
        ptr       <= 1'b0;
      end

      pv  <= pv_nxt[RD_LAT-1:0];
      pid <= pid_nxt[RD_LAT-1:0];

      bus.r0_rvalid <= pv_nxt[RD_LAT] & ~pid_nxt[RD_LAT];
      bus.r1_rvalid <= pv_nxt[RD_LAT] &  pid_nxt[RD_LAT];
      if (pv_nxt[RD_LAT]) begin
        if (pid_nxt[RD_LAT]) bus.r1_rdata <= bus.douta;
        else                 bus.r0_rdata <= bus.douta;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: transaction-level scoreboard checked every cycle plus directed literal checks.
module tb_ram_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int RL = 1;

  logic clka = 1'b0;
  logic rst;
  always #5 clka = ~clka;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clka (clka),
    .rst  (rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Block RAM model with one cycle of read latency
  logic [DW-1:0] ram [32];
  logic [DW-1:0] douta_r = '0;
  initial for (int i = 0; i < 32; i++) ram[i] = '0;
  always @(posedge clka) if (bus.ena) begin
    if (bus.wea) ram[bus.addra] <= bus.dina;
    else         douta_r <= ram[bus.addra];
  end
  assign bus.douta = douta_r;

  // Scoreboard: shadow memory and a queue of pending read returns
  typedef struct { int due; bit id; logic [DW-1:0] data; } rd_t;
  rd_t pend[$];
  logic [DW-1:0] shadow [32];
  initial for (int i = 0; i < 32; i++) shadow[i] = '0;

  int cyc = 0;
  bit m_ack0, m_ack1, m_ena, m_wea, m_rv0, m_rv1, m_last;
  logic [AW-1:0] m_addra;
  logic [DW-1:0] m_dina, m_rd0, m_rd1;

  always @(posedge clka) begin
    bit e0, e1, win;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit w;
    rd_t r;
    cyc++;
    if (rst) begin
      {m_ack0, m_ack1, m_ena, m_wea, m_rv0, m_rv1} = '0;
      m_addra = '0; m_dina = '0; m_rd0 = '0; m_rd1 = '0;
      m_last = 1'b1;  // so requester 0 is preferred first
      pend.delete();
    end else begin
      e0 = bus.r0_req && !m_ack0;
      e1 = bus.r1_req && !m_ack1;
      m_rv0 = 0; m_rv1 = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.id) begin m_rv1 = 1; m_rd1 = r.data; end
        else      begin m_rv0 = 1; m_rd0 = r.data; end
      end
      // round robin: on contention the one that did not win last time wins
      win = (e0 && e1) ? !m_last : e1;
      m_ena = e0 || e1;
      m_ack0 = m_ena && !win;
      m_ack1 = m_ena && win;
      m_wea = 0;
      if (m_ena) begin
        a = win ? bus.r1_addr  : bus.r0_addr;
        d = win ? bus.r1_wdata : bus.r0_wdata;
        w = win ? bus.r1_we    : bus.r0_we;
        m_wea = w; m_addra = a; m_dina = d; m_last = win;
        if (w) shadow[a] = d;
        else   pend.push_back('{cyc + RL + 1, win, shadow[a]});
      end
    end
  end

  always @(negedge clka) if (cyc > 0) begin
    chk("ena", bus.ena, m_ena);
    chk("wea", bus.wea, m_wea);
    chk("r0_ack", bus.r0_ack, m_ack0);
    chk("r1_ack", bus.r1_ack, m_ack1);
    chk("r0_rvalid", bus.r0_rvalid, m_rv0);
    chk("r1_rvalid", bus.r1_rvalid, m_rv1);
    chk("addra", bus.addra, m_addra);
    chk("dina", bus.dina, m_dina);
    chk("r0_rdata", bus.r0_rdata, m_rd0);
    chk("r1_rdata", bus.r1_rdata, m_rd1);
  end

  // Event logs used by the directed checks
  int ack1_cnt = 0, ena_cnt = 0;
  bit ack_log[$], rv_id[$];
  logic [DW-1:0] rv_data[$];
  always @(negedge clka) begin
    if (bus.r1_ack) ack1_cnt++;
    if (bus.ena) ena_cnt++;
    if (bus.r0_ack) ack_log.push_back(0);
    if (bus.r1_ack) ack_log.push_back(1);
    if (bus.r0_rvalid) begin rv_id.push_back(0); rv_data.push_back(bus.r0_rdata); end
    if (bus.r1_rvalid) begin rv_id.push_back(1); rv_data.push_back(bus.r1_rdata); end
  end

  int ack_cyc;
  logic snap_ena, snap_wea;
  logic [AW-1:0] snap_addra;
  logic [DW-1:0] snap_dina;

  // Present one transfer, wait for its ack, and release req in the following cycle
  task automatic do_xfer(input bit id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    bit acked = 0;
    if (id) begin bus.r1_req = 1; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d; end
    else    begin bus.r0_req = 1; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d; end
    while (!acked && n < 50) begin
      @(negedge clka); n++;
      acked = id ? bus.r1_ack : bus.r0_ack;
    end
    chk("xfer_ack", acked, 1);
    ack_cyc = cyc; snap_ena = bus.ena; snap_wea = bus.wea;
    snap_addra = bus.addra; snap_dina = bus.dina;
    @(posedge clka); #1;
    if (id) bus.r1_req = 0; else bus.r0_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  int wr_acked = 0;

  initial begin
    int n, c, e, rvc;
    bit seen;
    rst = 1;
    bus.r0_req = 1; bus.r0_we = 0; bus.r0_addr = 0; bus.r0_wdata = 0;
    bus.r1_req = 1; bus.r1_we = 0; bus.r1_addr = 1; bus.r1_wdata = 0;
    repeat (3) @(posedge clka);
    #1 rst = 0;

    // First grant after reset goes to requester 0
    n = 0; seen = 0;
    while (!seen && n < 10) begin @(negedge clka); n++; seen = bus.r0_ack | bus.r1_ack; end
    chk("first_ack_r0", bus.r0_ack, 1);
    chk("first_ack_not_r1", bus.r1_ack, 0);
    @(posedge clka); #1 bus.r0_req = 0;
    n = 0; seen = 0;
    while (!seen && n < 10) begin @(negedge clka); n++; seen = bus.r1_ack; end
    chk("second_ack_r1", seen, 1);
    @(posedge clka); #1 bus.r1_req = 0;
    idle(5);

    // Single write then read
    do_xfer(0, 1, 5, 8'hA5);
    chk("wr_ena", snap_ena, 1);
    chk("wr_wea", snap_wea, 1);
    chk("wr_addra", snap_addra, 5);
    chk("wr_dina", snap_dina, 8'hA5);
    do_xfer(0, 0, 5, 8'h00);
    chk("rd_wea", snap_wea, 0);
    n = 0; seen = 0;
    while (!seen && n < 10) begin @(negedge clka); n++; seen = bus.r0_rvalid; end
    chk("rd_latency", cyc - ack_cyc, 2);
    chk("rd_data", bus.r0_rdata, 8'hA5);
    chk("rd_other_rvalid", bus.r1_rvalid, 0);
    idle(3);

    // Contention: preload words, then both requesters read continuously
    do_xfer(0, 1, 3, 8'h33);
    do_xfer(1, 1, 7, 8'h77);
    idle(4);
    ack_log.delete(); rv_id.delete(); rv_data.delete();
    e = ena_cnt;
    fork
      repeat (3) do_xfer(0, 0, 3, 8'h00);
      repeat (3) do_xfer(1, 0, 7, 8'h00);
    join
    idle(5);
    chk("cont_acks", ack_log.size(), 6);
    chk("cont_ena", ena_cnt - e, 6);
    for (int k = 1; k < ack_log.size(); k++) chk("cont_alternate", ack_log[k] != ack_log[k-1], 1);
    chk("cont_rvalids", rv_id.size(), 6);
    for (int k = 0; k < rv_id.size() && k < ack_log.size(); k++) begin
      chk("cont_rv_order", rv_id[k], ack_log[k]);
      chk("cont_rv_data", rv_data[k], rv_id[k] ? 8'h77 : 8'h33);
    end

    // Held request masking: one ack, one RAM access
    c = ack1_cnt; e = ena_cnt;
    do_xfer(1, 0, 9, 8'h00);
    idle(6);
    chk("mask_one_ack", ack1_cnt - c, 1);
    chk("mask_one_access", ena_cnt - e, 1);

    // Reset in the cycle after a read ack discards the read
    do_xfer(0, 0, 5, 8'h00);
    rst = 1;
    @(posedge clka); #1 rst = 0;
    rvc = 0;
    repeat (6) begin @(negedge clka); if (bus.r0_rvalid) rvc++; end
    chk("midrst_no_rvalid", rvc, 0);
    chk("midrst_rdata", bus.r0_rdata, 0);
    idle(2);

    // Fill and readback
    fork
      for (int i = 0; i < 32; i++) begin
        do_xfer(0, 1, AW'(i), DW'(i));
        wr_acked = i + 1;
      end
      for (int i = 0; i < 32; i++) begin
        wait (wr_acked > i);
        @(posedge clka); #1;
        do_xfer(1, 0, AW'(i), 8'h00);
        n = 0; seen = 0;
        while (!seen && n < 10) begin @(negedge clka); n++; seen = bus.r1_rvalid; end
        chk("fill_rvalid", seen, 1);
        chk("fill_rdata", bus.r1_rdata, i);
      end
    join
    do_xfer(0, 1, 31, 8'hEE);
    chk("wrap_addr31", snap_addra, 31);
    do_xfer(0, 0, 0, 8'h00);
    chk("wrap_addr0", snap_addra, 0);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port block RAM (8-bit data, 32 words, 1-cycle read latency) between two requesters.
- Each requester issues single-word read or write transfers over a req/ack handshake.
- Round-robin arbitration selects one requester and drives the RAM port (ena, wea, addra, dina) from registers.
- Read data returns to the winning requester with a tagged valid strobe.
- Sits directly in front of the RAM IP in place of a single fixed sequencer.

Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 8, RAM data width
- RD_LAT, 1, RAM read latency in cycles (douta valid RD_LAT cycles after the ena cycle); legal range 1..3

Ports:
- clka  in  1  clock, all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- r0_req  in  1  requester 0 transfer request; held until r0_ack
- r0_we  in  1  requester 0: 1=write, 0=read; held with req
- r0_addr  in  ADDR_W  requester 0 address; held with req
- r0_wdata  in  DATA_W  requester 0 write data; held with req
- r0_ack  out  1  one-cycle pulse: requester 0 transfer issued to RAM this cycle
- r0_rdata  out  DATA_W  requester 0 read data
- r0_rvalid  out  1  one-cycle pulse: r0_rdata valid
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata, r1_rvalid  same as requester 0, for requester 1
- ena  out  1  RAM enable
- wea  out  1  RAM write enable
- addra  out  ADDR_W  RAM address
- dina  out  DATA_W  RAM write data
- douta  in  DATA_W  RAM read data

Behaviour:
- Reset (rst=1 at a clock edge):
  - ena, wea, r0_ack, r1_ack, r0_rvalid, r1_rvalid = 0.
  - addra, dina, r0_rdata, r1_rdata = 0.
  - Read-return pipeline flushed; priority pointer set to requester 0.
- Reset mid-operation: any in-flight read is discarded and no rvalid is emitted for it.
- Eligibility in cycle T: rN is eligible if rN_req=1 and rN_ack=0 in T. The ack mask prevents re-granting a request still held during its ack cycle.
- Arbitration (combinational, cycle T):
  - Only one eligible: it wins.
  - Both eligible: the requester named by the priority pointer wins.
  - None eligible: no grant.
- Issue (registered, cycle T+1 = ack cycle A):
  - On a grant to rN: ena=1, wea=rN_we, addra=rN_addr, dina=rN_wdata, rN_ack=1.
  - On no grant: ena=0, wea=0; addra and dina hold their previous values.
- Priority pointer: updates at the grant edge to the non-winning requester. It does not change when there is no grant.
- Handshake:
  - Requester holds req, we, addr and wdata stable from assertion through the cycle with ack=1.
  - Requester may drop req or present a new transfer the cycle after ack.
  - A requester held continuously gets at most one grant per 2 cycles.
  - Two requesters alternating get one RAM access per cycle (full throughput).
- Read return:
  - Each issued read pushes {valid, id} into an RD_LAT-deep shift pipeline; writes push nothing.
  - At cycle A+RD_LAT the pipeline head captures douta into r{id}_rdata.
  - r{id}_rvalid pulses in cycle A+RD_LAT+1.
  - The other requester's rdata and rvalid are unaffected.
  - rdata holds its value until the next rvalid for that requester.
- Ordering: read data is returned in issue order. Back-to-back reads from alternating requesters produce rvalid on consecutive cycles.
- Same-address write then read:
  - Read issued in the cycle after the write returns the new data.
  - No bypass logic is needed; the RAM provides this ordering.
- Write completion: ack only; there is no write response.
- Widths: addra and dina pass through unmodified; no arithmetic on data.

Test Plan:
- Reset: hold rst=1 for 3 cycles with r0_req=r1_req=1 -> ena=0, both acks=0, both rvalid=0 throughout. The first ack after rst falls goes to r0.
- Single write then read:
  - r0 writes addr 5, data 0xA5 -> ack cycle: ena=1, wea=1, addra=5, dina=0xA5.
  - r0 then reads addr 5 -> r0_rvalid pulses 2 cycles after its ack (RD_LAT=1), r0_rdata=0xA5, r1_rvalid stays 0.
- Contention: r0 and r1 both request reads (addr 3, addr 7) continuously for 6 cycles -> acks alternate r0,r1,r0,r1 with ena=1 every cycle. rvalid sequence follows the same order with the correct words.
- Held request masking: r1 alone holds req through its ack cycle, then drops it -> exactly one r1_ack and one RAM access. No duplicate grant.
- Reset mid-read: assert rst in the cycle after an r0 read ack -> no r0_rvalid appears. r0_rdata=0 after reset.
- Fill and readback: r0 writes 0..31 to addresses 0..31 while r1 concurrently reads addresses 0..31 after each write is acked -> every r1_rdata equals its address, and addra wraps 31->0 correctly.
